// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - PC owner, single-outstanding imem fetch FSM and prefetch FIFO
module instr_fetch_unit #(
   parameter logic [15:0] RESET_PC = 16'd10,
   parameter logic [15:0] PC_STEP  = 16'd2,
   parameter int          DEPTH    = 2
) (
   input  logic        Clock,
   input  logic        Reset,
   output logic        imem_req,
   output logic [15:0] imem_addr,
   input  logic        imem_ack,
   input  logic [15:0] imem_rdata,
   input  logic        redirect_valid,
   input  logic [15:0] redirect_pc,
   output logic        instr_valid,
   output logic [15:0] instr,
   output logic [15:0] instr_pc,
   input  logic        instr_ready
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

   state_t        state;
   logic [15:0]   fetch_pc;
   logic [15:0]   fifo_instr [DEPTH];
   logic [15:0]   fifo_pc    [DEPTH];
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic [CW-1:0] count;
   logic          push;
   logic          pop;

   // A redirect overrides any same-cycle push or pop so nothing stale survives the flush.
   always_comb begin
      push = 1'b0;
      pop  = 1'b0;
      if (!redirect_valid) begin
         push = (state == WAIT) && imem_ack;
         pop  = instr_valid && instr_ready;
      end
   end

   assign instr_valid = (count != '0);
   assign instr       = fifo_instr[rd_ptr];
   assign instr_pc    = fifo_pc[rd_ptr];

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state     <= IDLE;
         fetch_pc  <= RESET_PC;
         imem_req  <= 1'b0;
         imem_addr <= RESET_PC;
      end else begin
         case (state)
            IDLE: begin
               // Full gate uses the current count; a pop this cycle frees space next cycle.
               if (redirect_valid) begin
                  fetch_pc <= redirect_pc;
               end else if (count < FULL) begin
                  state     <= WAIT;
                  imem_req  <= 1'b1;
                  imem_addr <= fetch_pc;
               end
            end
            WAIT: begin
               if (redirect_valid) begin
                  fetch_pc <= redirect_pc;
                  if (imem_ack) begin
                     state    <= IDLE;
                     imem_req <= 1'b0;
                  end else begin
                     state <= DROP;
                  end
               end else if (imem_ack) begin
                  fetch_pc <= fetch_pc + PC_STEP;
                  state    <= IDLE;
                  imem_req <= 1'b0;
               end
            end
            DROP: begin
               if (redirect_valid) begin
                  fetch_pc <= redirect_pc;
               end
               if (imem_ack) begin
                  state    <= IDLE;
                  imem_req <= 1'b0;
               end
            end
            default: begin
               state    <= IDLE;
               imem_req <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            fifo_instr[i] <= '0;
            fifo_pc[i]    <= '0;
         end
      end else if (redirect_valid) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            fifo_instr[wr_ptr] <= imem_rdata;
            fifo_pc[wr_ptr]    <= fetch_pc;
            wr_ptr             <= wr_ptr + PW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         if (push && !pop) begin
            count <= count + CW'(1);
         end else if (pop && !push) begin
            count <= count - CW'(1);
         end
      end
   end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - scoreboard bench for instr_fetch_unit with a latency-programmable memory model
module tb_instr_fetch_unit;
   logic        Clock;
   logic        Reset;
   logic        imem_req;
   logic [15:0] imem_addr;
   logic        imem_ack;
   logic [15:0] imem_rdata;
   logic        redirect_valid;
   logic [15:0] redirect_pc;
   logic        instr_valid;
   logic [15:0] instr;
   logic [15:0] instr_pc;
   logic        instr_ready;

   int          n_cmp;
   int          n_fail;
   logic [31:0] sb [$];
   logic [15:0] popped [$];
   logic [15:0] exp_addr;
   logic [15:0] cur_addr;
   int          lat_cnt;
   int          mem_lat;
   bit          mem_en;
   bit          mem_rand;
   bit          req_seen;
   bit          drop_flag;

   instr_fetch_unit dut (
      .Clock          (Clock),
      .Reset          (Reset),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_ack       (imem_ack),
      .imem_rdata     (imem_rdata),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .instr_valid    (instr_valid),
      .instr          (instr),
      .instr_pc       (instr_pc),
      .instr_ready    (instr_ready)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   function automatic logic [15:0] mem_word(input logic [15:0] a);
      return {a[7:0], a[15:8]} ^ 16'hC3A5;
   endfunction

   // One clock: memory model and consumer act on outputs seen 1 time unit after the edge.
   task automatic tick();
      logic [31:0] e;
      if (Reset) begin
         sb.delete();
         req_seen  = 1'b0;
         drop_flag = 1'b0;
         exp_addr  = 16'h000A;
      end else begin
         n_cmp++;
         if (instr_valid !== (sb.size() != 0)) begin
            n_fail++;
            $display("FAIL valid_vs_count: instr_valid=%b expected %b", instr_valid, (sb.size() != 0));
         end
         if (imem_req) begin
            if (!req_seen) begin
               req_seen = 1'b1;
               cur_addr = exp_addr;
               lat_cnt  = mem_rand ? int'($urandom_range(1, 3)) : mem_lat;
            end
            n_cmp++;
            if (imem_addr !== cur_addr) begin
               n_fail++;
               $display("FAIL imem_addr: got %h expected %h", imem_addr, cur_addr);
            end
            if (mem_en) begin
               if (lat_cnt <= 1) begin
                  imem_ack   = 1'b1;
                  imem_rdata = mem_word(imem_addr);
                  req_seen   = 1'b0;
                  if (!drop_flag && !redirect_valid) begin
                     sb.push_back({cur_addr, mem_word(cur_addr)});
                     exp_addr = cur_addr + 16'd2;
                  end
                  drop_flag = 1'b0;
               end else begin
                  lat_cnt--;
               end
            end
         end
         if (instr_valid && instr_ready && !redirect_valid) begin
            n_cmp++;
            if (sb.size() == 0) begin
               n_fail++;
               $display("FAIL pop_unexpected: got pc %h, scoreboard empty", instr_pc);
            end else begin
               e = sb.pop_front();
               if (instr_pc !== e[31:16] || instr !== e[15:0]) begin
                  n_fail++;
                  $display("FAIL pop_data: got pc %h instr %h expected pc %h instr %h",
                           instr_pc, instr, e[31:16], e[15:0]);
               end
            end
            popped.push_back(instr_pc);
         end
         if (redirect_valid) begin
            sb.delete();
            if (imem_req && !imem_ack) drop_flag = 1'b1;
            exp_addr = redirect_pc;
         end
      end
      @(posedge Clock);
      #1;
      imem_ack = 1'b0;
   endtask

   task automatic do_reset();
      Reset          = 1'b1;
      redirect_valid = 1'b0;
      mem_en         = 1'b1;
      mem_rand       = 1'b0;
      tick();
      tick();
      Reset = 1'b0;
      popped.delete();
   endtask

   task automatic test_reset();
      Reset          = 1'b1;
      redirect_valid = 1'b0;
      instr_ready    = 1'b0;
      tick();
      n_cmp += 5;
      if (imem_req !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %b expected 0", imem_req); end
      if (imem_addr !== 16'h000A) begin n_fail++; $display("FAIL rst_addr: got %h expected 000a", imem_addr); end
      if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b expected 0", instr_valid); end
      if (instr !== 16'h0000) begin n_fail++; $display("FAIL rst_instr: got %h expected 0000", instr); end
      if (instr_pc !== 16'h0000) begin n_fail++; $display("FAIL rst_pc: got %h expected 0000", instr_pc); end
      Reset = 1'b0;
      tick();
      n_cmp += 2;
      if (imem_req !== 1'b1) begin n_fail++; $display("FAIL rst_first_req: got %b expected 1", imem_req); end
      if (imem_addr !== 16'h000A) begin n_fail++; $display("FAIL rst_first_addr: got %h expected 000a", imem_addr); end
   endtask

   task automatic test_sequential();
      do_reset();
      mem_lat     = 1;
      instr_ready = 1'b1;
      tick();
      tick();
      n_cmp += 2;
      if (instr_valid !== 1'b1) begin n_fail++; $display("FAIL seq_latency: valid=%b expected 1", instr_valid); end
      if (instr_pc !== 16'h000A) begin n_fail++; $display("FAIL seq_first_pc: got %h expected 000a", instr_pc); end
      repeat (12) tick();
      n_cmp++;
      if (popped.size() < 3) begin
         n_fail++;
         $display("FAIL seq_count: got %0d pops expected >=3", popped.size());
      end else if (popped[0] !== 16'h000A || popped[1] !== 16'h000C || popped[2] !== 16'h000E) begin
         n_fail++;
         $display("FAIL seq_order: got %h %h %h expected 000a 000c 000e", popped[0], popped[1], popped[2]);
      end
   endtask

   task automatic test_backpressure();
      do_reset();
      mem_lat     = 1;
      instr_ready = 1'b0;
      repeat (8) tick();
      n_cmp += 3;
      if (imem_req !== 1'b0) begin n_fail++; $display("FAIL bp_full_req: got %b expected 0", imem_req); end
      if (instr_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid: got %b expected 1", instr_valid); end
      if (instr_pc !== 16'h000A) begin n_fail++; $display("FAIL bp_head_pc: got %h expected 000a", instr_pc); end
      instr_ready = 1'b1;
      for (int k = 0; k < 10 && !imem_req; k++) tick();
      n_cmp++;
      if (imem_req !== 1'b1 || imem_addr !== 16'h000E) begin
         n_fail++;
         $display("FAIL bp_next_req: req=%b addr=%h expected 1 000e", imem_req, imem_addr);
      end
      for (int k = 0; k < 20 && popped.size() < 2; k++) tick();
      n_cmp++;
      if (popped.size() < 2) begin
         n_fail++;
         $display("FAIL bp_pops: got %0d pops expected >=2", popped.size());
      end else if (popped[0] !== 16'h000A || popped[1] !== 16'h000C) begin
         n_fail++;
         $display("FAIL bp_order: got %h %h expected 000a 000c", popped[0], popped[1]);
      end
   endtask

   task automatic test_redirect_wait();
      do_reset();
      mem_lat     = 3;
      instr_ready = 1'b1;
      for (int k = 0; k < 30 && !(imem_req && imem_addr == 16'h000C); k++) tick();
      n_cmp++;
      if (!(imem_req && imem_addr == 16'h000C)) begin
         n_fail++;
         $display("FAIL rw_timeout: req=%b addr=%h expected 1 000c", imem_req, imem_addr);
      end
      redirect_valid = 1'b1;
      redirect_pc    = 16'h0040;
      tick();
      redirect_valid = 1'b0;
      popped.delete();
      for (int k = 0; k < 10 && !(imem_req && imem_addr == 16'h0040); k++) begin
         n_cmp++;
         if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL rw_valid: got %b expected 0", instr_valid); end
         tick();
      end
      n_cmp++;
      if (!(imem_req && imem_addr == 16'h0040)) begin
         n_fail++;
         $display("FAIL rw_next_req: req=%b addr=%h expected 1 0040", imem_req, imem_addr);
      end
      repeat (10) tick();
      n_cmp++;
      if (popped.size() < 1 || popped[0] !== 16'h0040) begin
         n_fail++;
         $display("FAIL rw_first_pop: got %0d pops expected first pc 0040", popped.size());
      end
   endtask

   task automatic test_redirect_ack();
      do_reset();
      mem_lat     = 1;
      instr_ready = 1'b1;
      for (int k = 0; k < 20 && !(imem_req && imem_addr == 16'h000C); k++) tick();
      redirect_valid = 1'b1;
      redirect_pc    = 16'h0040;
      tick();
      redirect_valid = 1'b0;
      n_cmp += 2;
      if (imem_req !== 1'b0) begin n_fail++; $display("FAIL ra_idle: req=%b expected 0", imem_req); end
      if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL ra_empty: valid=%b expected 0", instr_valid); end
      tick();
      n_cmp++;
      if (imem_req !== 1'b1 || imem_addr !== 16'h0040) begin
         n_fail++;
         $display("FAIL ra_next_req: req=%b addr=%h expected 1 0040", imem_req, imem_addr);
      end
   endtask

   task automatic test_wrap();
      do_reset();
      mem_lat        = 1;
      instr_ready    = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc    = 16'hFFFE;
      tick();
      redirect_valid = 1'b0;
      popped.delete();
      for (int k = 0; k < 20 && popped.size() < 2; k++) tick();
      n_cmp++;
      if (popped.size() < 2) begin
         n_fail++;
         $display("FAIL wrap_pops: got %0d pops expected >=2", popped.size());
      end else if (popped[0] !== 16'hFFFE || popped[1] !== 16'h0000) begin
         n_fail++;
         $display("FAIL wrap_order: got %h %h expected fffe 0000", popped[0], popped[1]);
      end
   endtask

   task automatic test_reset_in_wait();
      do_reset();
      mem_lat     = 3;
      instr_ready = 1'b1;
      tick();
      tick();
      Reset = 1'b1;
      tick();
      Reset      = 1'b0;
      mem_en     = 1'b0;
      imem_ack   = 1'b1;
      imem_rdata = 16'hDEAD;
      tick();
      mem_en = 1'b1;
      n_cmp += 2;
      if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL stray_valid: got %b expected 0", instr_valid); end
      if (imem_req !== 1'b1 || imem_addr !== 16'h000A) begin
         n_fail++;
         $display("FAIL stray_req: req=%b addr=%h expected 1 000a", imem_req, imem_addr);
      end
      popped.delete();
      for (int k = 0; k < 20 && popped.size() < 1; k++) tick();
      n_cmp++;
      if (popped.size() < 1 || popped[0] !== 16'h000A) begin
         n_fail++;
         $display("FAIL stray_first_pop: got %0d pops expected first pc 000a", popped.size());
      end
   endtask

   task automatic test_back_to_back();
      int start;
      do_reset();
      mem_rand = 1'b1;
      start    = 0;
      for (int k = 0; k < 400; k++) begin
         instr_ready = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 29) == 0) begin
            redirect_valid = 1'b1;
            redirect_pc    = 16'($urandom) & 16'hFFFE;
         end
         tick();
         redirect_valid = 1'b0;
         start += popped.size();
         popped.delete();
      end
      mem_rand = 1'b0;
      n_cmp++;
      if (start < 50) begin
         n_fail++;
         $display("FAIL b2b_throughput: got %0d pops expected >=50", start);
      end
   endtask

   initial begin
      n_cmp          = 0;
      n_fail         = 0;
      Reset          = 1'b1;
      imem_ack       = 1'b0;
      imem_rdata     = 16'h0000;
      redirect_valid = 1'b0;
      redirect_pc    = 16'h0000;
      instr_ready    = 1'b0;
      mem_lat        = 1;
      mem_en         = 1'b1;
      mem_rand       = 1'b0;
      req_seen       = 1'b0;
      drop_flag      = 1'b0;
      exp_addr       = 16'h000A;
      cur_addr       = 16'h000A;
      lat_cnt        = 0;
      test_reset();
      test_sequential();
      test_backpressure();
      test_redirect_wait();
      test_redirect_ack();
      test_wrap();
      test_reset_in_wait();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
